// File: rtl/dmem_pkg.sv
// Shared encodings and the latched-request record for the data-memory arbiter.
// No logic; imported by the arbiter top and the lane-alignment helper.
// Size codes match the load/store unit's encoding; 2'b11 is reserved and treated as an error.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   // Attributes captured at grant time; id = 0 for m0, 1 for m1.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic        id;
   } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Purpose: byte-enable generation, store-lane placement and load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; evaluated from the latched request every ACCESS cycle.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_a,
   input  logic        i_uns,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_mem_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);

   logic [4:0]  w_shamt;
   logic [31:0] w_sh;

   assign w_shamt = {i_a, 3'b000};
   assign w_sh    = i_mem_rdata >> w_shamt;

   // Decode size/offset into lanes, shifted store data and extended load data.
   always_comb begin
      o_be       = 4'b0000;
      o_wdata    = 32'h0;
      o_rdata    = 32'h0;
      o_misalign = 1'b0;
      case (i_size)
         SZ_B: begin
            o_be    = 4'b0001 << i_a;
            o_wdata = {24'h0, i_wdata[7:0]} << w_shamt;
            o_rdata = i_uns ? {24'h0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
         end
         SZ_H: begin
            o_misalign = i_a[0];
            o_be       = 4'b0011 << i_a;
            o_wdata    = {16'h0, i_wdata[15:0]} << w_shamt;
            o_rdata    = i_uns ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
         end
         SZ_W: begin
            o_misalign = |i_a;
            o_be       = 4'b1111;
            o_wdata    = i_wdata;
            o_rdata    = w_sh;
         end
         default: o_misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: two-master arbiter/controller in front of the byte-addressed data memory.
// Latency: gnt @N, memory driven @N+1, registered response @N+2; one access per cycle.
// Backpressure: the loser of arbitration keeps its request up until its combinational gnt.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   parameter bit          RR_EN     = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [1:0]  m0_size,
   input  logic        m0_uns,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [1:0]  m1_size,
   input  logic        m1_uns,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_t      r_state;
   req_t        r_req;
   logic        r_last_gnt;     // 1 = m1 won the last accept
   logic        r_m0_rvalid;
   logic        r_m1_rvalid;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_any;
   logic        w_sel_m1;
   req_t        w_new;
   logic        w_act;
   logic        w_err;
   logic        w_misalign;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_rdata;

   // m1 wins when alone, or on a tie when round-robin says it is m1's turn.
   assign w_any    = m0_req | m1_req;
   assign w_sel_m1 = m1_req & (~m0_req | (RR_EN & ~r_last_gnt));
   assign m0_gnt   = m0_req & ~w_sel_m1;
   assign m1_gnt   = w_sel_m1;

   assign w_new = w_sel_m1 ?
      '{we: m1_we, addr: m1_addr, size: m1_size, uns: m1_uns, wdata: m1_wdata, id: 1'b1} :
      '{we: m0_we, addr: m0_addr, size: m0_size, uns: m0_uns, wdata: m0_wdata, id: 1'b0};

   dmem_lane_align u_align (
      .i_size      (r_req.size),
      .i_a         (r_req.addr[1:0]),
      .i_uns       (r_req.uns),
      .i_wdata     (r_req.wdata),
      .i_mem_rdata (mem_rdata),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_rdata     (w_rdata),
      .o_misalign  (w_misalign)
   );

   assign w_act = (r_state == ST_ACCESS);
   assign w_err = w_misalign | (r_req.addr >= 32'(MEM_BYTES));

   assign mem_addr  = w_act ? {r_req.addr[31:2], 2'b00} : 32'h0;
   assign mem_we    = w_act & r_req.we & ~w_err;
   assign mem_be    = (w_act & ~w_err) ? w_be : 4'b0000;
   assign mem_wdata = (w_act & r_req.we & ~w_err) ? w_wdata : 32'h0;

   assign m0_rvalid  = r_m0_rvalid;
   assign m1_rvalid  = r_m1_rvalid;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   // Accept on any request from either state; otherwise fall back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_req      <= '0;
         r_last_gnt <= 1'b1;
      end else if (w_any) begin
         r_state    <= ST_ACCESS;
         r_req      <= w_new;
         r_last_gnt <= w_sel_m1;
      end else begin
         r_state    <= ST_IDLE;
      end
   end

   // Register the response of the access that ends at this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_rdata     <= 32'h0;
         r_err       <= 1'b0;
      end else if (w_act) begin
         r_m0_rvalid <= ~r_req.id;
         r_m1_rvalid <= r_req.id;
         r_rdata     <= (r_req.we | w_err) ? 32'h0 : w_rdata;
         r_err       <= w_err;
      end else begin
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_rdata     <= 32'h0;
         r_err       <= 1'b0;
      end
   end

endmodule
